linear_network_multicast_pipe: RTL and testbench
================================================

# linear_network_multicast_pipe

Pipelined, flow-controlled multicast chain: one input port feeds a linear string of NUM_NODE register stages, and stage k delivers to node k when bit k of the flit's multi-hot destination tag is set. It is the registered successor of the combinational linear multicast network. It adds a per-stage pipeline register, valid/ready backpressure on the input and on every node output, a global freeze enable, and early retirement of flits once no destinations remain. It sits between a distribution buffer and a row of PEs in the NoC.

## Interface
- DATA_WIDTH, 32, flit payload width; only width matters, no format interpretation.
- NUM_NODE, 4, number of stages/destination nodes (≥1); also the destination tag width.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  input flit valid.
- i_data_bus  input  DATA_WIDTH  input payload.
- i_cmd  input  NUM_NODE  multi-hot destination tag; bit k = deliver to node k.
- o_ready  output  1  input accept; transfer when i_valid & o_ready.
- o_valid  output  NUM_NODE  per-node delivery valid.
- o_data_bus  output  NUM_NODE*DATA_WIDTH  node k payload at [k*DATA_WIDTH+:DATA_WIDTH].
- i_ready  input  NUM_NODE  per-node sink ready; delivery k completes when o_valid[k] & i_ready[k].
- i_en  input  1  global enable; low freezes the whole chain.
- o_busy  output  1  any stage holds a flit.

## Operation
- Stage k register: vld_k, data_k, tag_k (NUM_NODE bits), done_k (delivery to node k completed).
- Node output: o_valid[k] = i_en & vld_k & tag_k[k] & ~done_k. o_data_bus slice k = data_k when o_valid[k], else {DATA_WIDTH{1'b0}} (dummy data).
- Delivery complete at k: dlv_k = ~tag_k[k] | done_k | (o_valid[k] & i_ready[k]).
- Remaining destinations: rem_k = |tag_k[NUM_NODE-1:k+1]. For the last stage, rem = 0.
- Stage k vacates (free_k) when ~vld_k, or when i_en & dlv_k & (~rem_k | adv_k). adv_k = move to k+1, allowed when rem_k & free_{k+1}.
- Retirement: a flit with dlv_k & ~rem_k leaves the chain at stage k and does not occupy later stages.
- On a move, stage k+1 loads data_k and tag_k, with done_{k+1}=0. done_k sets on a handshake that does not coincide with a vacate, and clears whenever the stage loads.
- Input: o_ready = i_en & free_0. On accept, stage 0 loads i_data_bus and i_cmd with done_0=0. If i_cmd==0, the flit is accepted and dropped: stage 0 is not loaded, and no output pulses.
- i_en low: o_ready=0, o_valid=0, and no register changes. Contents are held and resume unchanged when i_en returns high.
- Order preserved: flits never overtake. Node k sees flits in acceptance order.
- Arbitrary multicast: any tag pattern is legal. Each set bit yields exactly one handshake at its node.
- o_busy = |vld.

## Timing
- Reset (async assert, rst_n low): all vld/done/tag/data = 0. The outputs are then o_valid=0, o_data_bus=0, o_busy=0, and o_ready = i_en.
- Release is synchronous in effect: the first accept can happen on the first rising edge with rst_n high.
- Latency: a flit accepted at edge t presents o_valid[k] during cycle t+1+k, given no stalls, i_ready all 1, and i_en high.
- Throughput: one flit per cycle when sinks are ready. A full chain with all sinks ready accepts every cycle, because free propagates combinationally from stage NUM_NODE-1 down to stage 0.
- Stall: if node k is not ready, stage k holds. Upstream stages fill and then o_ready drops. Downstream flits keep draining.
- Partial delivery: o_valid[k] deasserts the cycle after its handshake even while the flit is held because stage k+1 is full. There is no duplicate delivery.
- Simultaneous events: a stage may vacate and load in the same edge. Handshake and vacate on the same edge leave done=0 for the new flit.
- Reset mid-operation: all in-flight flits are discarded with no further o_valid pulses.

## Test plan
- NUM_NODE=4, i_cmd=4'b0001, data 32'hAAAAAAAA, i_ready=4'hF → o_valid=4'b0001 one cycle after accept, and o_busy returns to 0 the next cycle (early retire).
- i_cmd=4'b1110, data 32'hBBBBBBBB, all ready → o_valid[1], [2], [3] pulse at accept+2, +3, +4. Slices carry BBBBBBBB. o_valid[0] never fires, and slice 0 stays 0.
- Back-to-back 8 flits with tag 4'b1111 and incrementing data, all ready → o_ready stays 1. Each node sees data 0..7 in order, one per cycle.
- i_ready[2]=0 for 5 cycles with a stream of tag 4'b1111 → o_ready falls within 3 cycles. Node 3 keeps draining older flits. After release, no flit is lost or duplicated at any node.
- i_en=0 for 3 cycles mid-stream → o_valid=0 and o_ready=0 during the freeze. After i_en=1 the sequence resumes identically, with latency extended by 3.
- rst_n pulsed low mid-stream and asynchronously → o_valid=0, o_busy=0, o_data_bus=0 immediately. A new flit afterwards is delivered normally.

Source files
------------

// File: rtl/linear_network_multicast_pipe.sv
// linear_network_multicast_pipe
// Pipelined multicast chain. Stage k delivers its flit to node k when tag bit k
// is set. Once a flit has no destinations left, it retires instead of moving on.
//
// Handshake rule: a transfer happens on a rising edge only when valid and ready
// are both high. Valid never depends on the ready it is paired with. The input
// side transfers when i_valid & o_ready. Node k transfers when
// o_valid[k] & i_ready[k].
module linear_network_multicast_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_NODE   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_valid,
  input  logic [DATA_WIDTH-1:0]          i_data_bus,
  input  logic [NUM_NODE-1:0]            i_cmd,
  output logic                           o_ready,
  output logic [NUM_NODE-1:0]            o_valid,
  output logic [NUM_NODE*DATA_WIDTH-1:0] o_data_bus,
  input  logic [NUM_NODE-1:0]            i_ready,
  input  logic                           i_en,
  output logic                           o_busy
);

  // Per-stage state
  logic [NUM_NODE-1:0]   vld_q;
  logic [NUM_NODE-1:0]   done_q;
  logic [DATA_WIDTH-1:0] data_q [NUM_NODE];
  logic [NUM_NODE-1:0]   tag_q  [NUM_NODE];

  // Per-stage control
  logic [NUM_NODE-1:0]   ov;        // node output valid
  logic [NUM_NODE-1:0]   hs;        // node handshake this cycle
  logic [NUM_NODE-1:0]   dlv;       // delivery to own node complete
  logic [NUM_NODE-1:0]   rem;       // destinations remain further down
  logic [NUM_NODE-1:0]   move;      // flit moves from k to k+1
  logic [NUM_NODE-1:0]   vacate;    // occupied stage empties this edge
  logic [NUM_NODE:0]     free_ext;  // stage k can take a new flit; top entry is a sentinel
  logic [NUM_NODE-1:0]   load;      // stage k loads a new flit
  logic [DATA_WIDTH-1:0] in_data [NUM_NODE];
  logic [NUM_NODE-1:0]   in_tag  [NUM_NODE];
  logic                  accept;

  // Delivery, retirement and the free chain. Free ripples from the last stage
  // down to stage 0, so a full chain that is draining still accepts every cycle.
  always_comb begin
    ov       = '0;
    hs       = '0;
    dlv      = '0;
    rem      = '0;
    move     = '0;
    vacate   = '0;
    free_ext = '0;
    for (int k = 0; k < NUM_NODE; k++) begin
      ov[k]  = i_en & vld_q[k] & tag_q[k][k] & ~done_q[k];
      hs[k]  = ov[k] & i_ready[k];
      dlv[k] = ~tag_q[k][k] | done_q[k] | hs[k];
      for (int j = 0; j < NUM_NODE; j++) begin
        if (j > k) rem[k] = rem[k] | tag_q[k][j];
      end
    end
    // The last stage never has remaining destinations, so the sentinel stays 0.
    for (int k = NUM_NODE - 1; k >= 0; k--) begin
      move[k]     = vld_q[k] & i_en & dlv[k] & rem[k] & free_ext[k+1];
      vacate[k]   = vld_q[k] & i_en & dlv[k] & (~rem[k] | move[k]);
      free_ext[k] = ~vld_q[k] | vacate[k];
    end
  end

  // Load sources. Stage 0 takes from the input, and every later stage takes
  // from its predecessor. A zero tag is accepted but never loaded.
  always_comb begin
    accept     = i_valid & i_en & free_ext[0];
    load       = '0;
    in_data[0] = i_data_bus;
    in_tag[0]  = i_cmd;
    load[0]    = accept & (|i_cmd);
    for (int k = 1; k < NUM_NODE; k++) begin
      in_data[k] = data_q[k-1];
      in_tag[k]  = tag_q[k-1];
      load[k]    = move[k-1];
    end
  end

  // Output drive. The payload is zeroed whenever a node is not being offered a flit.
  always_comb begin
    o_ready    = i_en & free_ext[0];
    o_valid    = ov;
    o_busy     = |vld_q;
    o_data_bus = '0;
    for (int k = 0; k < NUM_NODE; k++) begin
      if (ov[k]) o_data_bus[k*DATA_WIDTH +: DATA_WIDTH] = data_q[k];
    end
  end

  // Stage registers. When a stage loads, that wins over a vacate on the same edge,
  // so the new flit always starts with done cleared. All enables include i_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      done_q <= '0;
      for (int k = 0; k < NUM_NODE; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_NODE; k++) begin
        if (load[k]) begin
          vld_q[k]  <= 1'b1;
          done_q[k] <= 1'b0;
          data_q[k] <= in_data[k];
          tag_q[k]  <= in_tag[k];
        end else if (vacate[k]) begin
          vld_q[k]  <= 1'b0;
          done_q[k] <= 1'b0;
        end else if (hs[k]) begin
          done_q[k] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_linear_network_multicast_pipe.sv
// Directed bench for linear_network_multicast_pipe (DATA_WIDTH=32, NUM_NODE=4).
module tb_linear_network_multicast_pipe;
  localparam int DW = 32;
  localparam int NN = 4;
  localparam int GD = 256;

  logic             clk;
  logic             rst_n;
  logic             i_valid;
  logic [DW-1:0]    i_data_bus;
  logic [NN-1:0]    i_cmd;
  logic             o_ready;
  logic [NN-1:0]    o_valid;
  logic [NN*DW-1:0] o_data_bus;
  logic [NN-1:0]    i_ready;
  logic             i_en;
  logic             o_busy;

  linear_network_multicast_pipe #(.DATA_WIDTH(DW), .NUM_NODE(NN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .i_cmd      (i_cmd),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus),
    .i_ready    (i_ready),
    .i_en       (i_en),
    .o_busy     (o_busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [NN*DW-1:0] bus_of(input logic [NN-1:0] v, input logic [DW-1:0] d);
    logic [NN*DW-1:0] b;
    b = '0;
    for (int k = 0; k < NN; k++) if (v[k]) b[k*DW +: DW] = d;
    return b;
  endfunction

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [NN-1:0] exp_tag_q[$];
  logic [DW-1:0] got_data [NN][GD];
  int            got_cnt  [NN];
  int            got_base [NN];

  initial for (int k = 0; k < NN; k++) got_cnt[k] = 0;

  // Record every completed node handshake. Inputs only change at posedge+1.
  always @(negedge clk) begin
    for (int k = 0; k < NN; k++) begin
      if (o_valid[k] && i_ready[k]) begin
        if (got_cnt[k] < GD) got_data[k][got_cnt[k]] = o_data_bus[k*DW +: DW];
        got_cnt[k] = got_cnt[k] + 1;
      end
    end
  end

  task automatic sb_mark();
    for (int k = 0; k < NN; k++) got_base[k] = got_cnt[k];
  endtask

  task automatic sb_check(input string name);
    int idx;
    for (int k = 0; k < NN; k++) begin
      idx = 0;
      foreach (exp_q[i]) begin
        if (exp_tag_q[i][k]) begin
          if (got_base[k] + idx < GD)
            check_val($sformatf("%s_n%0d_%0d", name, k, idx), got_data[k][got_base[k] + idx], exp_q[i]);
          idx++;
        end
      end
      check_val($sformatf("%s_n%0d_cnt", name, k), got_cnt[k] - got_base[k], idx);
    end
    exp_q.delete();
    exp_tag_q.delete();
    sb_mark();
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one flit until it is accepted. Called at posedge+1 and returns at posedge+1.
  task automatic send(input logic [DW-1:0] d, input logic [NN-1:0] c, output int waits);
    bit ok;
    ok = 0;
    waits = 0;
    i_valid = 1'b1;
    i_data_bus = d;
    i_cmd = c;
    for (int w = 0; w < 40 && !ok; w++) begin
      @(negedge clk);
      if (o_ready) begin
        ok = 1;
        if (c != '0) begin
          exp_q.push_back(d);
          exp_tag_q.push_back(c);
        end
      end else begin
        waits++;
      end
      step();
    end
    if (!ok) check_val("send_timeout", 0, 1);
    i_valid = 1'b0;
    i_data_bus = '0;
    i_cmd = '0;
  endtask

  task automatic accept_one(input string name, input logic [DW-1:0] d, input logic [NN-1:0] c);
    i_valid = 1'b1;
    i_data_bus = d;
    i_cmd = c;
    @(negedge clk);
    check_val({name, "_oready"}, o_ready, 1'b1);
    if (c != '0) begin
      exp_q.push_back(d);
      exp_tag_q.push_back(c);
    end
    step();
    i_valid = 1'b0;
    i_data_bus = '0;
    i_cmd = '0;
  endtask

  task automatic drain(input string name);
    for (int w = 0; w < 60 && o_busy; w++) step();
    check_val({name, "_drain"}, o_busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  int w;
  bit fell;
  int fell_c;
  int n3;
  logic [NN-1:0] ev;

  initial begin
    rst_n = 1'b0;
    i_en = 1'b1;
    i_valid = 1'b0;
    i_data_bus = '0;
    i_cmd = '0;
    i_ready = 4'hF;
    #12;
    check_val("rst_ovalid", o_valid, 4'b0000);
    check_val("rst_busy", o_busy, 1'b0);
    check_val("rst_data", o_data_bus, '0);
    check_val("rst_oready_en1", o_ready, 1'b1);
    i_en = 1'b0;
    #1;
    check_val("rst_oready_en0", o_ready, 1'b0);
    i_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    sb_mark();

    // Single destination at node 0, which retires early
    accept_one("t1", 32'hAAAAAAAA, 4'b0001);
    @(negedge clk);
    check_val("t1_ovalid", o_valid, 4'b0001);
    check_val("t1_data", o_data_bus, bus_of(4'b0001, 32'hAAAAAAAA));
    check_val("t1_busy", o_busy, 1'b1);
    @(negedge clk);
    check_val("t1_ovalid_after", o_valid, 4'b0000);
    check_val("t1_busy_after", o_busy, 1'b0);
    step();
    sb_check("t1");

    // Tag 1110: nodes 1..3 at accept+2..+4, and node 0 never fires
    accept_one("t2", 32'hBBBBBBBB, 4'b1110);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      ev = (n == 1) ? 4'b0000 : (4'b0001 << (n - 1));
      check_val($sformatf("t2_ovalid_c%0d", n), o_valid, ev);
      check_val($sformatf("t2_data_c%0d", n), o_data_bus, bus_of(ev, 32'hBBBBBBBB));
    end
    @(negedge clk);
    check_val("t2_busy_after", o_busy, 1'b0);
    step();
    sb_check("t2");

    // A zero tag is accepted and dropped
    accept_one("t0", 32'h12345678, 4'b0000);
    @(negedge clk);
    check_val("t0_busy", o_busy, 1'b0);
    check_val("t0_ovalid", o_valid, 4'b0000);
    step();

    // Back-to-back stream at full throughput
    for (int i = 0; i < 8; i++) begin
      send(i, 4'b1111, w);
      check_val($sformatf("t3_stall_%0d", i), w, 0);
    end
    drain("t3");
    sb_check("t3");

    // Node 2 stalls for 5 cycles in the middle of a stream
    fork
      begin
        for (int i = 0; i < 12; i++) send(100 + i, 4'b1111, w);
      end
      begin
        repeat (4) step();
        i_ready = 4'b1011;
        n3 = got_cnt[3];
        fell = 0;
        fell_c = 0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (!o_ready && !fell) begin
            fell = 1;
            fell_c = c;
          end
          step();
        end
        check_val("t4_ready_fell", (fell && fell_c <= 2), 1'b1);
        check_val("t4_node3_drained", (got_cnt[3] > n3), 1'b1);
        i_ready = 4'hF;
      end
    join
    drain("t4");
    sb_check("t4");

    // Freeze for 3 cycles right after an accept: latency grows by 3
    accept_one("t5", 32'hCCCCCCCC, 4'b1000);
    i_en = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      check_val($sformatf("t5_frz_ovalid_%0d", n), o_valid, 4'b0000);
      check_val($sformatf("t5_frz_oready_%0d", n), o_ready, 1'b0);
      check_val($sformatf("t5_frz_busy_%0d", n), o_busy, 1'b1);
    end
    step();
    i_en = 1'b1;
    for (int n = 4; n <= 7; n++) begin
      @(negedge clk);
      ev = (n == 7) ? 4'b1000 : 4'b0000;
      check_val($sformatf("t5_ovalid_c%0d", n), o_valid, ev);
      check_val($sformatf("t5_data_c%0d", n), o_data_bus, bus_of(ev, 32'hCCCCCCCC));
    end
    @(negedge clk);
    check_val("t5_busy_after", o_busy, 1'b0);
    step();
    sb_check("t5");

    // Asynchronous reset while flits are in flight
    send(32'h11111111, 4'b1111, w);
    send(32'h22222222, 4'b1111, w);
    #3;
    check_val("t6_inflight", (o_valid != 4'b0000), 1'b1);
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_ovalid", o_valid, 4'b0000);
    check_val("t6_rst_busy", o_busy, 1'b0);
    check_val("t6_rst_data", o_data_bus, '0);
    @(negedge clk);
    exp_q.delete();
    exp_tag_q.delete();
    sb_mark();
    rst_n = 1'b1;
    step();
    repeat (3) step();
    sb_check("t6_quiet");
    accept_one("t6", 32'hDDDDDDDD, 4'b0101);
    drain("t6");
    sb_check("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
